// File: rtl/sccb_pkg.sv
// Shared types and constants for the write-only SCCB master.
package sccb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      BIT,
      STOP,
      GAP
   } sccb_state_e;

   localparam int SCCB_FRAME_BITS = 27;
   localparam int SCCB_QUARTERS   = 4;
   localparam int DONT_CARE_IDX0  = 8;
   localparam int DONT_CARE_IDX1  = 17;
   localparam int DONT_CARE_IDX2  = 26;

   // Bit positions where the slave owns the line (ACK slot, never sampled).
   function automatic logic is_dont_care(input logic [4:0] idx);
      return (idx == 5'(DONT_CARE_IDX0)) ||
             (idx == 5'(DONT_CARE_IDX1)) ||
             (idx == 5'(DONT_CARE_IDX2));
   endfunction

endpackage

// File: rtl/sccb_writer_qtick.sv
// Quarter-bit-period divider: strobes qtick every QTR_CYCLES clocks and
// tracks the quarter index; held cleared while en is low.
module sccb_qtick
   import sccb_pkg::*;
#(
   parameter int QTR_CYCLES = 125
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       qtick,
   output logic [1:0] quarter
);

   localparam int CW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(QTR_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    quarter_q, quarter_d;

   always_comb begin
      cnt_d     = cnt_q;
      quarter_d = quarter_q;
      if (!en) begin
         cnt_d     = '0;
         quarter_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d     = '0;
         quarter_d = quarter_q + 2'd1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         quarter_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         quarter_q <= quarter_d;
      end
   end

   assign qtick   = en && (cnt_q == CNT_LAST);
   assign quarter = quarter_q;

endmodule

// File: rtl/sccb_writer.sv
// Write-only SCCB master: latches one {ID, register, data} command per
// request and shifts it out as a 3-phase write with registered pin outputs.
module sccb_writer
   import sccb_pkg::*;
#(
   parameter logic [7:0] SID        = 8'h60,
   parameter int         QTR_CYCLES = 125,
   parameter int         GAP_CYCLES = 500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       send,
   input  logic [7:0] rega,
   input  logic [7:0] value,
   output logic       taken,
   output logic       busy,
   output logic       sioc,
   inout  wire        siod
);

   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [4:0]    BIT_LAST = 5'(SCCB_FRAME_BITS - 1);
   localparam logic [1:0]    Q_LAST   = 2'(SCCB_QUARTERS - 1);

   sccb_state_e state_q, state_d;
   logic [4:0]                 bit_idx_q, bit_idx_d;
   logic [GW-1:0]              gap_q, gap_d;
   logic [SCCB_FRAME_BITS-1:0] frame_q, frame_d;
   logic taken_q, taken_d;
   logic busy_q, busy_d;
   logic sioc_q, sioc_d;
   logic siod_q, siod_d;
   logic oe_q, oe_d;

   logic       qtick;
   logic [1:0] quarter;
   logic       phase_end;

   sccb_qtick #(
      .QTR_CYCLES(QTR_CYCLES)
   ) u_qtick (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (state_q != IDLE),
      .qtick  (qtick),
      .quarter(quarter)
   );

   assign phase_end = qtick && (quarter == Q_LAST);

   // Pin values are computed from the current phase/quarter and registered,
   // so the bus trails the state machine by one clock uniformly.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      gap_d     = gap_q;
      frame_d   = frame_q;
      taken_d   = 1'b0;
      sioc_d    = 1'b1;
      siod_d    = 1'b1;
      oe_d      = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (send) begin
               frame_d = {SID, 1'b1, rega, 1'b1, value, 1'b1};
               taken_d = 1'b1;
               state_d = START;
            end
         end
         START: begin
            sioc_d = (quarter != 2'd3);
            siod_d = (quarter < 2'd2);
            if (phase_end) begin
               state_d   = BIT;
               bit_idx_d = '0;
            end
         end
         BIT: begin
            sioc_d = quarter[1];
            siod_d = siod_q;
            oe_d   = oe_q;
            if (quarter != 2'd0) begin
               siod_d = frame_q[SCCB_FRAME_BITS-1];
               oe_d   = !is_dont_care(bit_idx_q);
            end
            if (phase_end) begin
               frame_d = frame_q << 1;
               if (bit_idx_q == BIT_LAST) state_d = STOP;
               else                       bit_idx_d = bit_idx_q + 5'd1;
            end
         end
         STOP: begin
            sioc_d = quarter[1];
            siod_d = (quarter == 2'd3);
            if (phase_end) begin
               state_d = GAP;
               gap_d   = '0;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_d = IDLE;
            else                   gap_d = gap_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bit_idx_q <= '0;
         gap_q     <= '0;
         frame_q   <= '0;
         taken_q   <= 1'b0;
         busy_q    <= 1'b0;
         sioc_q    <= 1'b1;
         siod_q    <= 1'b1;
         oe_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         gap_q     <= gap_d;
         frame_q   <= frame_d;
         taken_q   <= taken_d;
         busy_q    <= busy_d;
         sioc_q    <= sioc_d;
         siod_q    <= siod_d;
         oe_q      <= oe_d;
      end
   end

   assign taken = taken_q;
   assign busy  = busy_q;
   assign sioc  = sioc_q;
   assign siod  = oe_q ? siod_q : 1'bz;

endmodule

// File: tb/tb_sccb_writer.sv
// Directed bench for sccb_writer: decodes the SCCB bus and checks frames,
// pulse counts and transaction timing with QTR_CYCLES=4, GAP_CYCLES=8.
module tb_sccb_writer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       send = 1'b0;
   logic [7:0] rega = 8'h00;
   logic [7:0] value = 8'h00;
   logic       taken, busy, sioc;
   wire        siod;

   int total = 0;
   int bad = 0;

   sccb_writer #(
      .SID       (8'h60),
      .QTR_CYCLES(4),
      .GAP_CYCLES(8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .send (send),
      .rega (rega),
      .value(value),
      .taken(taken),
      .busy (busy),
      .sioc (sioc),
      .siod (siod)
   );

   always #5 clk = ~clk;

   // Bus monitor: START/STOP detection and bit capture on sioc rising edges.
   int          cyc = 0;
   int          taken_cnt = 0;
   int          taken_last = 0;
   int          taken_period = 0;
   int          busy_rise = 0;
   int          busy_len = 0;
   int          starts = 0;
   int          stops = 0;
   int          nbits = 0;
   logic [27:0] rx = '0;
   logic [27:0] rx_q[$];
   int          nbits_q[$];
   logic        prev_sioc = 1'b1;
   logic        prev_siod = 1'b1;
   logic        prev_busy = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (taken === 1'b1) begin
         taken_cnt++;
         taken_period = cyc - taken_last;
         taken_last = cyc;
      end
      if (busy === 1'b1 && !prev_busy) busy_rise = cyc;
      if (busy !== 1'b1 && prev_busy)  busy_len = cyc - busy_rise;
      prev_busy = (busy === 1'b1);
      if (prev_sioc && sioc === 1'b1) begin
         if (prev_siod === 1'b1 && siod === 1'b0) begin
            starts++;
            nbits = 0;
            rx = '0;
         end else if (prev_siod === 1'b0 && siod === 1'b1) begin
            stops++;
            rx_q.push_back(rx);
            nbits_q.push_back(nbits);
         end
      end else if (!prev_sioc && sioc === 1'b1) begin
         rx = {rx[26:0], siod};
         nbits++;
      end
      prev_sioc = (sioc === 1'b1);
      prev_siod = siod;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy === 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   // Received frame layout: 27 data slots then the STOP-phase sioc rise.
   task automatic check_frame(input string tag, input logic [7:0] ra, input logic [7:0] va);
      logic [27:0] f;
      int          nb;
      chk({tag, "_present"}, 32'(rx_q.size() > 0), 32'd1);
      if (rx_q.size() > 0) begin
         f  = rx_q.pop_front();
         nb = nbits_q.pop_front();
         chk({tag, "_nbits"}, 32'(nb), 32'd28);
         chk({tag, "_id"},    {24'd0, f[27:20]}, 32'h60);
         chk({tag, "_rega"},  {24'd0, f[18:11]}, {24'd0, ra});
         chk({tag, "_value"}, {24'd0, f[9:2]},   {24'd0, va});
      end
   endtask

   task automatic one_shot(input logic [7:0] ra, input logic [7:0] va);
      rega  = ra;
      value = va;
      send  = 1'b1;
      tick();
      send  = 1'b0;
   endtask

   logic [15:0] exp_q[$];
   int          t0, s0, p0;
   logic [15:0] e;

   initial begin
      // Reset values held during reset
      tick();
      chk("rst_sioc",  {31'd0, sioc},  32'd1);
      chk("rst_siod",  {31'd0, siod},  32'd1);
      chk("rst_taken", {31'd0, taken}, 32'd0);
      chk("rst_busy",  {31'd0, busy},  32'd0);
      rst_n = 1'b1;

      // Idle with send low
      t0 = taken_cnt;
      repeat (100) tick();
      chk("idle_taken_cnt", 32'(taken_cnt - t0), 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_sioc", {31'd0, sioc}, 32'd1);
      chk("idle_siod", {31'd0, siod}, 32'd1);

      // Single command 0x12 <- 0x80
      rx_q.delete(); nbits_q.delete();
      t0 = taken_cnt; s0 = starts; p0 = stops;
      one_shot(8'h12, 8'h80);
      chk("one_taken_hi", {31'd0, taken}, 32'd1);
      chk("one_busy_hi",  {31'd0, busy},  32'd1);
      tick();
      chk("one_taken_lo", {31'd0, taken}, 32'd0);
      wait_idle("one_timeout");
      repeat (3) tick();
      chk("one_taken_cnt", 32'(taken_cnt - t0), 32'd1);
      chk("one_starts", 32'(starts - s0), 32'd1);
      chk("one_stops",  32'(stops - p0),  32'd1);
      chk("one_busy_len", 32'(busy_len), 32'd472);
      check_frame("one", 8'h12, 8'h80);

      // Back-to-back with send held high and inputs changing every cycle
      rx_q.delete(); nbits_q.delete();
      t0 = taken_cnt;
      send = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         rega  = 8'(c * 7 + 3);
         value = 8'(c) ^ 8'h5A;
         tick();
         if (taken === 1'b1) exp_q.push_back({rega, value});
      end
      send = 1'b0;
      wait_idle("b2b_timeout");
      repeat (3) tick();
      chk("b2b_taken_cnt", 32'(taken_cnt - t0), 32'd4);
      chk("b2b_period", 32'(taken_period), 32'd473);
      chk("b2b_frames", 32'(rx_q.size()), 32'd4);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_frame("b2b", e[15:8], e[7:0]);
      end

      // 0xFF / 0x00: data may only move while sioc is low
      rx_q.delete(); nbits_q.delete();
      s0 = starts; p0 = stops;
      one_shot(8'hFF, 8'h00);
      wait_idle("ff_timeout");
      repeat (3) tick();
      chk("ff_starts", 32'(starts - s0), 32'd1);
      chk("ff_stops",  32'(stops - p0),  32'd1);
      check_frame("ff", 8'hFF, 8'h00);

      // Asynchronous reset at clk 200 of a transaction
      one_shot(8'h55, 8'hAA);
      repeat (199) tick();
      chk("mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_sioc",  {31'd0, sioc},  32'd1);
      chk("arst_siod",  {31'd0, siod},  32'd1);
      chk("arst_busy",  {31'd0, busy},  32'd0);
      chk("arst_taken", {31'd0, taken}, 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      rx_q.delete(); nbits_q.delete();
      one_shot(8'h3C, 8'hA5);
      wait_idle("post_rst_timeout");
      repeat (3) tick();
      chk("post_rst_busy_len", 32'(busy_len), 32'd472);
      check_frame("post_rst", 8'h3C, 8'hA5);

      // send dropped at clk 50: frame completes, no second command
      rx_q.delete(); nbits_q.delete();
      t0 = taken_cnt;
      rega  = 8'h0A;
      value = 8'h5C;
      send  = 1'b1;
      tick();
      repeat (49) tick();
      send = 1'b0;
      wait_idle("drop_timeout");
      repeat (600) tick();
      chk("drop_taken_cnt", 32'(taken_cnt - t0), 32'd1);
      chk("drop_busy_len", 32'(busy_len), 32'd472);
      chk("drop_busy", {31'd0, busy}, 32'd0);
      check_frame("drop", 8'h0A, 8'h5C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
